pll_spi_master: RTL and testbench

Parametrised, queued SPI register writer for synthesizer/PLL-class devices: 3-wire write-only bus (CLK, DATA, LE), MSB first. Generalised successor to the team's single-channel 32-bit ADF4159 loader:
- configurable word width;
- programmable bit timing;
- multiple latch-enable lines, so one master serves several devices on a shared CLK/DATA pair;
- a command FIFO with valid/ready handshake, so the control FSM can queue a full register bank without polling `busy`.

The block sits between the board-level configuration sequencer and the device pins.

---
 rtl/pll_spi_pkg.sv | 39 +++
 rtl/pll_spi_cmd_fifo.sv | 61 ++++++
 rtl/pll_spi_master.sv | 168 ++++++++++++++++
 tb/tb_pll_spi_master.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_spi_pkg.sv
// Shared types and default parameters for the queued 3-wire PLL register writer.
// Command word is sized for the widest legal configuration; modules use the low bits.
package pll_spi_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NUM_CS     = 2;
    localparam int DEF_CLK_HALF   = 2;
    localparam int DEF_LE_SETUP   = 3;
    localparam int DEF_LE_HOLD    = 2;
    localparam int DEF_LE_GAP     = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int CS_MAX_W   = 3;
    localparam int DATA_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        BIT_LO,
        BIT_HI,
        HOLD,
        GAP
    } state_t;

    typedef struct packed {
        logic [CS_MAX_W-1:0]   cs;
        logic [DATA_MAX_W-1:0] data;
    } cmd_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_spi_cmd_fifo.sv
// Synchronous command FIFO with registered count/full/empty; head word is read combinationally.
// Push is ignored when full and pop when empty, so callers may gate loosely.
module pll_spi_cmd_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pll_spi_master.sv
// Queued MSB-first 3-wire register writer with per-device LE; push-to-LE-low is 2 cycles.
// wr_ready drops only on registered FIFO full; a same-cycle pop does not reopen it.
module pll_spi_master
    import pll_spi_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_CS     = DEF_NUM_CS,
    parameter int CLK_HALF   = DEF_CLK_HALF,
    parameter int LE_SETUP   = DEF_LE_SETUP,
    parameter int LE_HOLD    = DEF_LE_HOLD,
    parameter int LE_GAP     = DEF_LE_GAP,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CS_W-1:0]   wr_cs,
    output logic              spi_clk,
    output logic              spi_data,
    output logic [NUM_CS-1:0] spi_le,
    output logic              busy,
    output logic              done,
    output logic              cs_err
);

    localparam int BC_W  = $clog2(DATA_W + 1);
    localparam int DLY_W = $clog2(max4(CLK_HALF, LE_SETUP, LE_HOLD, LE_GAP) + 1);

    state_t              state;
    state_t              state_nxt;
    logic [DLY_W-1:0]    dly;
    logic [DLY_W-1:0]    dly_nxt;
    logic [BC_W-1:0]     bit_cnt;
    logic [BC_W-1:0]     bit_nxt;
    cmd_t                cmd_q;
    cmd_t                cmd_nxt;
    cmd_t                head;
    logic [CS_W+DATA_W-1:0] fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                data_nxt;
    logic                clk_nxt;
    logic                done_nxt;
    logic                err_nxt;
    logic [NUM_CS-1:0]   le_nxt;

    assign wr_ready = rst && !fifo_full;
    assign busy     = !fifo_empty || (state != IDLE);

    pll_spi_cmd_fifo #(
        .WIDTH (CS_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_valid && wr_ready),
        .din   ({wr_cs, wr_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        head = '0;
        head.cs[CS_W-1:0]     = fifo_dout[CS_W+DATA_W-1:DATA_W];
        head.data[DATA_W-1:0] = fifo_dout[DATA_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        dly_nxt   = dly + DLY_W'(1);
        bit_nxt   = bit_cnt;
        cmd_nxt   = cmd_q;
        data_nxt  = spi_data;
        pop       = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                dly_nxt = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_nxt = head;
                    // Out-of-range channel is dropped without touching the pins
                    if ({1'b0, head.cs} >= 4'(NUM_CS)) err_nxt = 1'b1;
                    else                               state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (dly == DLY_W'(LE_SETUP - 1)) begin
                    state_nxt = BIT_LO;
                    dly_nxt   = '0;
                    bit_nxt   = '0;
                    data_nxt  = cmd_q.data[DATA_W-1];
                end
            end
            BIT_LO: begin
                if (dly == DLY_W'(CLK_HALF - 1)) begin
                    state_nxt = BIT_HI;
                    dly_nxt   = '0;
                end
            end
            BIT_HI: begin
                if (dly == DLY_W'(CLK_HALF - 1)) begin
                    dly_nxt      = '0;
                    cmd_nxt.data = cmd_q.data << 1;
                    bit_nxt      = bit_cnt + BC_W'(1);
                    if (bit_cnt == BC_W'(DATA_W - 1)) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = BIT_LO;
                        data_nxt  = cmd_q.data[DATA_W-2];
                    end
                end
            end
            HOLD: begin
                if (dly == DLY_W'(LE_HOLD - 1)) begin
                    state_nxt = GAP;
                    dly_nxt   = '0;
                end
            end
            GAP: begin
                if (dly == DLY_W'(LE_GAP - 1)) begin
                    state_nxt = IDLE;
                    dly_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Pins are registered from the next state so they change glitch-free on one edge
        clk_nxt  = (state_nxt != BIT_LO);
        done_nxt = (state == HOLD) && (state_nxt == GAP);
        le_nxt   = '1;
        if (state_nxt inside {SETUP, BIT_LO, BIT_HI, HOLD}) begin
            le_nxt = ~(NUM_CS'(1) << cmd_nxt.cs);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            dly      <= '0;
            bit_cnt  <= '0;
            cmd_q    <= '0;
            spi_clk  <= 1'b1;
            spi_data <= 1'b0;
            spi_le   <= '1;
            done     <= 1'b0;
            cs_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dly      <= dly_nxt;
            bit_cnt  <= bit_nxt;
            cmd_q    <= cmd_nxt;
            spi_clk  <= clk_nxt;
            spi_data <= data_nxt;
            spi_le   <= le_nxt;
            done     <= done_nxt;
            cs_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pll_spi_master.sv
// Bench for pll_spi_master: a pin-level monitor rebuilds frames, tasks compare them with expectations.
module tb_pll_spi_master;

    localparam int FRAME   = 3 + 2 * 2 * 32 + 2;
    localparam int LEGAP   = 4;
    localparam int SPACING = FRAME + LEGAP + 1;
    localparam int FRAME2  = 1 + 2 * 1 * 24 + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests_run = 0;
    int   failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_cs = '0;
    logic        spi_clk, spi_data, busy, done, cs_err;
    logic [2:0]  spi_le;

    logic        wr_valid2 = 1'b0;
    logic        wr_ready2;
    logic [23:0] wr_data2 = '0;
    logic [0:0]  wr_cs2 = '0;
    logic        spi_clk2, spi_data2, busy2, done2, cs_err2;
    logic [1:0]  spi_le2;

    pll_spi_master #(.DATA_W(32), .NUM_CS(3)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_cs(wr_cs), .spi_clk(spi_clk), .spi_data(spi_data),
        .spi_le(spi_le), .busy(busy), .done(done), .cs_err(cs_err)
    );

    pll_spi_master #(.DATA_W(24), .NUM_CS(2), .CLK_HALF(1), .LE_SETUP(1), .LE_HOLD(1)) dut2 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
        .wr_data(wr_data2), .wr_cs(wr_cs2), .spi_clk(spi_clk2), .spi_data(spi_data2),
        .spi_le(spi_le2), .busy(busy2), .done(done2), .cs_err(cs_err2)
    );

    typedef struct {
        int          cs;
        logic [63:0] data;
        int          bits;
        int          len;
        int          start;
        int          rise;
        bit          done_at_rise;
    } frame_t;

    frame_t      frames[$];
    int          cur_cs, cur_bits, cur_len, cur_start;
    logic [63:0] cur_data;
    int          done_cnt = 0, err_cnt = 0, multi_low = 0, data_viol = 0;
    logic [2:0]  prev_le = 3'b111;
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b0;

    // Rebuild each frame as a device would see it: LE window, bits sampled on spi_clk rising
    always @(negedge clk) begin
        frame_t f;
        if (spi_le != 3'b111 && prev_le == 3'b111) begin
            cur_bits = 0; cur_len = 0; cur_data = '0; cur_start = cyc; cur_cs = -1;
            for (int i = 0; i < 3; i++) if (!spi_le[i]) cur_cs = i;
        end
        if (spi_le != 3'b111) begin
            cur_len++;
            if (spi_clk && !prev_clk) begin
                cur_data = {cur_data[62:0], spi_data};
                cur_bits++;
            end
            if ($countones(~spi_le) > 1) multi_low++;
            if (prev_le != 3'b111 && spi_data !== prev_data && !(prev_clk && !spi_clk)) data_viol++;
        end
        if (spi_le == 3'b111 && prev_le != 3'b111) begin
            f.cs = cur_cs; f.data = cur_data; f.bits = cur_bits; f.len = cur_len;
            f.start = cur_start; f.rise = cyc; f.done_at_rise = done;
            frames.push_back(f);
        end
        if (done === 1'b1) done_cnt++;
        if (cs_err === 1'b1) err_cnt++;
        prev_le = spi_le; prev_clk = spi_clk; prev_data = spi_data;
    end

    task automatic push(input logic [31:0] d, input logic [1:0] c, output bit ok, output int acc);
        ok = 0; acc = -1;
        @(negedge clk);
        wr_valid = 1'b1; wr_data = d; wr_cs = c;
        for (int i = 0; i < 3000; i++) begin
            if (wr_ready) begin acc = cyc; ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic push2(input logic [23:0] d, input logic [0:0] c, output bit ok);
        ok = 0;
        @(negedge clk);
        wr_valid2 = 1'b1; wr_data2 = d; wr_cs2 = c;
        for (int i = 0; i < 500; i++) begin
            if (wr_ready2) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1 wr_valid2 = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (spi_clk !== 1'b1) begin failed++; $display("FAIL reset_spi_clk: got %b want 1", spi_clk); end
        tests_run++; if (spi_data !== 1'b0) begin failed++; $display("FAIL reset_spi_data: got %b want 0", spi_data); end
        tests_run++; if (spi_le !== 3'b111) begin failed++; $display("FAIL reset_spi_le: got %b want 111", spi_le); end
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || cs_err !== 1'b0) begin
            failed++; $display("FAIL reset_flags: busy/done/cs_err got %b%b%b want 000", busy, done, cs_err); end
        tests_run++; if (wr_ready !== 1'b0) begin failed++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        tests_run++; if (spi_le2 !== 2'b11 || spi_clk2 !== 1'b1) begin
            failed++; $display("FAIL reset_dut2: le %b clk %b want 11 1", spi_le2, spi_clk2); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if (wr_ready !== 1'b1) begin failed++; $display("FAIL release_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_single();
        bit ok; int acc; int d0;
        frames.delete(); d0 = done_cnt;
        push(32'hA5A5_0003, 2'd1, ok, acc);
        tests_run++; if (!ok) begin failed++; $display("FAIL single_push: not accepted"); end
        wait_idle(1000, ok);
        tests_run++; if (!ok) begin failed++; $display("FAIL single_idle: busy never fell"); end
        tests_run++; if (frames.size() != 1) begin failed++; $display("FAIL single_count: got %0d frames want 1", frames.size()); end
        if (frames.size() >= 1) begin
            tests_run++; if (frames[0].cs != 1) begin failed++; $display("FAIL single_cs: got %0d want 1", frames[0].cs); end
            tests_run++; if (frames[0].bits != 32 || frames[0].data[31:0] !== 32'hA5A5_0003) begin
                failed++; $display("FAIL single_data: got %0d bits %h want 32 bits a5a50003", frames[0].bits, frames[0].data); end
            tests_run++; if (frames[0].len != FRAME) begin failed++; $display("FAIL single_len: got %0d want %0d", frames[0].len, FRAME); end
            tests_run++; if (!frames[0].done_at_rise) begin failed++; $display("FAIL single_done_at_rise: got 0 want 1"); end
        end
        tests_run++; if (done_cnt - d0 != 1) begin failed++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_queue_fill();
        logic [31:0] d[6];
        int          c[6];
        bit          ok;
        int          acc, occ;
        frames.delete();
        for (int k = 1; k <= 5; k++) begin
            d[k-1] = $urandom; c[k-1] = (k - 1) % 2;
            push(d[k-1], 2'(c[k-1]), ok, acc);
            tests_run++; if (!ok) begin failed++; $display("FAIL fill_push%0d: not accepted", k); end
            @(negedge clk);
            // The first word moves into the shifter one check later, freeing its slot
            occ = k - ((k >= 2) ? 1 : 0);
            tests_run++; if (wr_ready !== (occ < 4)) begin
                failed++; $display("FAIL fill_ready%0d: got %b want %b", k, wr_ready, (occ < 4)); end
        end
        d[5] = $urandom; c[5] = 2;
        push(d[5], 2'(c[5]), ok, acc);
        tests_run++; if (!ok) begin failed++; $display("FAIL fill_push6: never accepted"); end
        wait_idle(3000, ok);
        tests_run++; if (!ok) begin failed++; $display("FAIL fill_idle: busy never fell"); end
        tests_run++; if (frames.size() != 6) begin failed++; $display("FAIL fill_count: got %0d want 6", frames.size()); end
        for (int i = 0; i < 6 && i < frames.size(); i++) begin
            tests_run++; if (frames[i].cs != c[i] || frames[i].data[31:0] !== d[i] || frames[i].bits != 32) begin
                failed++; $display("FAIL fill_frame%0d: cs %0d data %h bits %0d want cs %0d data %h bits 32",
                                   i, frames[i].cs, frames[i].data[31:0], frames[i].bits, c[i], d[i]); end
            if (i > 0) begin
                tests_run++; if (frames[i].start - frames[i-1].start != SPACING) begin
                    failed++; $display("FAIL fill_spacing%0d: got %0d want %0d", i, frames[i].start - frames[i-1].start, SPACING); end
            end
        end
        if (frames.size() >= 1) begin
            tests_run++; if (acc != frames[0].rise + LEGAP + 1) begin
                failed++; $display("FAIL full_pop_refuse: accepted at %0d want %0d", acc, frames[0].rise + LEGAP + 1); end
        end
    endtask

    task automatic test_invalid_cs();
        bit ok; int acc; int e0, d0;
        logic [31:0] dv;
        frames.delete(); e0 = err_cnt; d0 = done_cnt; dv = $urandom;
        push($urandom, 2'd3, ok, acc);
        push(dv, 2'd2, ok, acc);
        wait_idle(1000, ok);
        tests_run++; if (err_cnt - e0 != 1) begin failed++; $display("FAIL inv_cs_err: got %0d pulses want 1", err_cnt - e0); end
        tests_run++; if (frames.size() != 1) begin failed++; $display("FAIL inv_frames: got %0d want 1", frames.size()); end
        if (frames.size() >= 1) begin
            tests_run++; if (frames[0].cs != 2 || frames[0].data[31:0] !== dv) begin
                failed++; $display("FAIL inv_next: cs %0d data %h want cs 2 data %h", frames[0].cs, frames[0].data[31:0], dv); end
        end
        tests_run++; if (done_cnt - d0 != 1) begin failed++; $display("FAIL inv_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_random();
        logic [31:0] exp_d[$];
        int          exp_c[$];
        int          exp_err, e0, acc;
        bit          ok;
        logic [31:0] d;
        int          c;
        frames.delete(); e0 = err_cnt; exp_err = 0;
        for (int k = 0; k < 10; k++) begin
            d = $urandom; c = $urandom_range(0, 3);
            if (c < 3) begin exp_d.push_back(d); exp_c.push_back(c); end
            else exp_err++;
            push(d, 2'(c), ok, acc);
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        wait_idle(5000, ok);
        tests_run++; if (!ok) begin failed++; $display("FAIL rand_idle: busy never fell"); end
        tests_run++; if (err_cnt - e0 != exp_err) begin failed++; $display("FAIL rand_err: got %0d want %0d", err_cnt - e0, exp_err); end
        tests_run++; if (frames.size() != exp_d.size()) begin
            failed++; $display("FAIL rand_count: got %0d want %0d", frames.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < frames.size(); i++) begin
            tests_run++; if (frames[i].cs != exp_c[i] || frames[i].data[31:0] !== exp_d[i] || frames[i].len != FRAME) begin
                failed++; $display("FAIL rand_frame%0d: cs %0d data %h len %0d want cs %0d data %h len %0d",
                                   i, frames[i].cs, frames[i].data[31:0], frames[i].len, exp_c[i], exp_d[i], FRAME); end
        end
    endtask

    task automatic test_sweep();
        bit          ok, plc;
        logic [23:0] d, cap;
        logic [0:0]  c;
        int          len, bits, dn, other;
        for (int it = 0; it < 3; it++) begin
            d = 24'($urandom); c = 1'($urandom_range(0, 1));
            push2(d, c, ok);
            tests_run++; if (!ok) begin failed++; $display("FAIL sweep_push%0d: not accepted", it); end
            len = 0; bits = 0; cap = '0; dn = 0; other = 0; plc = 1'b1;
            for (int i = 0; i < 120; i++) begin
                @(negedge clk);
                if (spi_le2 != 2'b11) begin
                    len++;
                    if (spi_clk2 && !plc) begin cap = {cap[22:0], spi_data2}; bits++; end
                    if (spi_le2[c] !== 1'b0) other++;
                end
                if (done2) dn++;
                plc = spi_clk2;
            end
            tests_run++; if (len != FRAME2) begin failed++; $display("FAIL sweep_len%0d: got %0d want %0d", it, len, FRAME2); end
            tests_run++; if (bits != 24 || cap !== d) begin
                failed++; $display("FAIL sweep_data%0d: got %0d bits %h want 24 bits %h", it, bits, cap, d); end
            tests_run++; if (dn != 1 || other != 0) begin
                failed++; $display("FAIL sweep_le%0d: done %0d wrong-line %0d want 1 0", it, dn, other); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok; int acc; int d0;
        frames.delete(); d0 = done_cnt;
        push($urandom, 2'd0, ok, acc);
        push($urandom, 2'd1, ok, acc);
        push($urandom, 2'd0, ok, acc);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (spi_le != 3'b111 && cur_bits >= 10) begin ok = 1; break; end
        end
        tests_run++; if (!ok) begin failed++; $display("FAIL midrst_reach: bit 10 never reached"); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (spi_le !== 3'b111 || spi_clk !== 1'b1 || spi_data !== 1'b0) begin
            failed++; $display("FAIL midrst_pins: le %b clk %b data %b want 111 1 0", spi_le, spi_clk, spi_data); end
        tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin
            failed++; $display("FAIL midrst_flags: busy %b done %b want 0 0", busy, done); end
        rst = 1'b1;
        repeat (300) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            failed++; $display("FAIL midrst_flushed: busy %b wr_ready %b want 0 1", busy, wr_ready); end
        tests_run++; if (frames.size() != 1) begin failed++; $display("FAIL midrst_frames: got %0d want 1 partial", frames.size()); end
        if (frames.size() >= 1) begin
            tests_run++; if (frames[0].done_at_rise || frames[0].bits >= 32) begin
                failed++; $display("FAIL midrst_partial: done %0d bits %0d want 0 and <32", frames[0].done_at_rise, frames[0].bits); end
        end
        tests_run++; if (done_cnt != d0) begin failed++; $display("FAIL midrst_done: got %0d pulses want 0", done_cnt - d0); end
    endtask

    task automatic test_protocol();
        tests_run++; if (multi_low != 0) begin failed++; $display("FAIL one_le_low: got %0d cycles with >1 low want 0", multi_low); end
        tests_run++; if (data_viol != 0) begin failed++; $display("FAIL data_edge: got %0d changes off falling edge want 0", data_viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue_fill();
        test_invalid_cs();
        test_random();
        test_sweep();
        test_reset_mid_frame();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
